// File: rtl/display_scan_scheduler.sv
// Multiplexed 8-digit display scanner. Each frame takes a coherent snapshot of
// the processor values, then walks the eight digit slots. Each slot opens with
// a blanking phase for ghost suppression and then shows its digit. Page 0 shows
// R0..R3 and page 1 shows PC. The page can be toggled on request or rotated
// automatically. AN, digit_nibble and frame_start are registered. They are
// computed from the next-state values, so they line up with the state they
// describe.
module display_scan_scheduler #(
    parameter int DWELL_CYCLES = 65536,
    parameter int BLANK_CYCLES = 1024,
    parameter int PAGE_FRAMES  = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] PC,
    input  logic [7:0] R0,
    input  logic [7:0] R1,
    input  logic [7:0] R2,
    input  logic [7:0] R3,
    input  logic       auto_rotate,
    input  logic       page_req,
    input  logic       hold,
    output logic [7:0] AN,
    output logic [3:0] digit_nibble,
    output logic       page,
    output logic       frame_start
);

    localparam int TW = $clog2(DWELL_CYCLES);
    localparam int FW = $clog2(PAGE_FRAMES) + 1;
    localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] SHOW_LOAD  = TW'(DWELL_CYCLES - BLANK_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(PAGE_FRAMES - 1);

    typedef enum logic [1:0] {SNAP, BLANK, SHOW} state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    digit, digit_next;
    logic          run;
    logic          snap_act;
    logic          pending;
    logic [FW-1:0] frame_cnt;
    logic          auto_req;
    logic          toggle;
    logic [7:0]    snap_pc, snap_r0, snap_r1, snap_r2, snap_r3;
    logic [7:0]    an_next;
    logic [3:0]    nibble_next;

    // Nibble shown for a digit on a page, taken from the snapshot.
    function automatic logic [3:0] pick_nibble(
        input logic       pg,
        input logic [2:0] d,
        input logic [7:0] pc,
        input logic [7:0] r0,
        input logic [7:0] r1,
        input logic [7:0] r2,
        input logic [7:0] r3
    );
        logic [7:0] byte_sel;
        if (pg) begin
            byte_sel = (d[2:1] == 2'd0) ? pc : 8'h00;
        end else begin
            case (d[2:1])
                2'd0:    byte_sel = r0;
                2'd1:    byte_sel = r1;
                2'd2:    byte_sel = r2;
                default: byte_sel = r3;
            endcase
        end
        return d[0] ? byte_sel[3:0] : byte_sel[7:4];
    endfunction

    // Toggle requests are resolved only in SNAP. Any source, or both, gives one toggle.
    assign auto_req = snap_act && auto_rotate && (frame_cnt == FRAME_LAST);
    assign toggle   = snap_act && (pending || auto_req);

    // Run flag: the idle cycle after reset release lets the first edge enter SNAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run <= 1'b0;
        else     run <= 1'b1;
    end

    // FSM state register with its slot timer and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SNAP;
            timer <= '0;
            digit <= 3'd0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            digit <= digit_next;
        end
    end

    // Next state. The timer reloads on every transition and counts down to zero.
    always_comb begin
        state_next = state;
        timer_next = timer;
        digit_next = digit;
        snap_act   = 1'b0;
        if (!run) begin
            state_next = SNAP;
        end else begin
            case (state)
                SNAP: begin
                    snap_act   = 1'b1;
                    digit_next = 3'd0;
                    timer_next = BLANK_LOAD;
                    state_next = BLANK;
                end
                BLANK: begin
                    if (timer == '0) begin
                        timer_next = SHOW_LOAD;
                        state_next = SHOW;
                    end else begin
                        timer_next = timer - 1'b1;
                    end
                end
                SHOW: begin
                    if (timer == '0) begin
                        if (digit == 3'd7) begin
                            timer_next = '0;
                            state_next = SNAP;
                        end else begin
                            digit_next = digit + 3'd1;
                            timer_next = BLANK_LOAD;
                            state_next = BLANK;
                        end
                    end else begin
                        timer_next = timer - 1'b1;
                    end
                end
                default: begin
                    timer_next = '0;
                    digit_next = 3'd0;
                    state_next = SNAP;
                end
            endcase
        end
    end

    // Output decode for the cycle being entered. Page and snapshot only change
    // when leaving SNAP, so the current values are valid whenever SHOW is entered.
    always_comb begin
        an_next     = 8'hFF;
        nibble_next = 4'h0;
        if (state_next == SHOW && !(page && digit_next >= 3'd2)) begin
            an_next     = ~(8'h01 << digit_next);
            nibble_next = pick_nibble(page, digit_next, snap_pc,
                                      snap_r0, snap_r1, snap_r2, snap_r3);
        end
    end

    // Registered outputs. The asynchronous reset blanks the anodes at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AN           <= 8'hFF;
            digit_nibble <= 4'h0;
            frame_start  <= 1'b0;
        end else begin
            AN           <= an_next;
            digit_nibble <= nibble_next;
            frame_start  <= (state_next == SNAP);
        end
    end

    // Snapshot of live values, refreshed only in SNAP and only when not held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_pc <= 8'h00;
            snap_r0 <= 8'h00;
            snap_r1 <= 8'h00;
            snap_r2 <= 8'h00;
            snap_r3 <= 8'h00;
        end else if (snap_act && !hold) begin
            snap_pc <= PC;
            snap_r0 <= R0;
            snap_r1 <= R1;
            snap_r2 <= R2;
            snap_r3 <= R3;
        end
    end

    // Sticky page request. A pulse landing in SNAP itself is kept for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           pending <= 1'b0;
        else if (snap_act) pending <= page_req;
        else if (page_req) pending <= 1'b1;
    end

    // Auto-rotate frame counter. It is held at zero while rotation is off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               frame_cnt <= '0;
        else if (!auto_rotate) frame_cnt <= '0;
        else if (snap_act)     frame_cnt <= auto_req ? '0 : frame_cnt + 1'b1;
    end

    // Page select register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         page <= 1'b0;
        else if (toggle) page <= ~page;
    end

endmodule

// File: doc/display_scan_scheduler.md
DISPLAY_SCAN_SCHEDULER -- requirements
Module: display_scan_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 65536: total clock cycles per digit slot, blank phase included; legal range BLANK_CYCLES+1 or more.
REQ-002 Parameter BLANK_CYCLES, default 1024: leading cycles of each digit slot with all anodes off, for ghost suppression; legal range 1 or more.
REQ-003 Parameter PAGE_FRAMES, default 256: complete frames per page when auto-rotating; legal range 1 or more.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Ports PC, R0, R1, R2, R3, input, 8 each: live processor values to be displayed.
REQ-007 Port auto_rotate, input, 1: when 1, the page toggles every PAGE_FRAMES frames.
REQ-008 Port page_req, input, 1: single-cycle pulse requesting a page toggle at the next frame boundary.
REQ-009 Port hold, input, 1: when 1, the snapshot is not refreshed at frame boundaries.
REQ-010 Port AN, output, 8: anode enables, active-low, at most one bit low.
REQ-011 Port digit_nibble, output, 4: hex value for the currently enabled digit, fed to the 7-segment decoder.
REQ-012 Port page, output, 1: 0 = register page, 1 = PC page.
REQ-013 Port frame_start, output, 1: single-cycle pulse in the SNAP cycle.

Function
REQ-014 The FSM SHALL have exactly three states: SNAP, BLANK and SHOW.
REQ-015 SNAP SHALL last exactly 1 cycle and perform these actions:
- latch {PC, R0..R3} into the snapshot registers unless hold=1;
- apply any pending page toggle;
- clear digit to 0;
- assert frame_start;
- go to BLANK.
REQ-016 BLANK SHALL drive AN=8'hFF for BLANK_CYCLES cycles and then go to SHOW.
REQ-017 SHOW SHALL last DWELL_CYCLES-BLANK_CYCLES cycles and drive AN[digit]=0 with all other bits 1. Exception: the digit is suppressed and AN stays 8'hFF while page=1 and digit is 2 or greater.
REQ-018 At the end of SHOW, the FSM SHALL go as follows:
- digit below 7: increment digit and go to BLANK;
- digit 7: go to SNAP.
REQ-019 Frame length SHALL be exactly 8*DWELL_CYCLES+1 cycles.
REQ-020 Page 0 mapping, digits 0..7: R0[7:4], R0[3:0], R1[7:4], R1[3:0], R2[7:4], R2[3:0], R3[7:4], R3[3:0], all taken from the snapshot.
REQ-021 Page 1 mapping: digit 0 = PC[7:4], digit 1 = PC[3:0], both from the snapshot; digit_nibble=4'h0 for digits 2..7.
REQ-022 digit_nibble SHALL be a registered output, valid in the same cycle as the corresponding AN low, and equal to 4'h0 whenever AN=8'hFF.
REQ-023 page_req SHALL set a sticky pending flag, which is cleared in SNAP.
- Multiple pulses within one frame SHALL produce a single toggle.
- A pulse coinciding with the SNAP cycle SHALL apply at the following frame boundary.
REQ-024 Frame counter, width clog2(PAGE_FRAMES)+1:
- increments in SNAP while auto_rotate=1;
- on reaching PAGE_FRAMES it requests a toggle and wraps to 0;
- clears whenever auto_rotate=0.
REQ-025 A simultaneous auto-rotate request and pending page_req in the same SNAP SHALL produce exactly one toggle.
REQ-026 Snapshot registers SHALL change only in SNAP; live input changes mid-frame SHALL never alter displayed digits.
REQ-027 The slot timer SHALL be sized clog2(DWELL_CYCLES) bits and SHALL reload on every state transition; no wrap-around artefacts are allowed.

Reset
REQ-028 While rst=1, outputs SHALL be AN=8'hFF, digit_nibble=4'h0, page=0 and frame_start=0.
- Internal state: snapshot, digit, timers, frame counter and pending flag all cleared to 0.
REQ-029 After rst deasserts, the first clock edge SHALL enter SNAP.
REQ-030 Reset asserted mid-frame SHALL force AN=8'hFF immediately, without waiting for a clock edge, and discard any pending toggle.

Verification (DWELL_CYCLES=8, BLANK_CYCLES=2, PAGE_FRAMES=2)
REQ-031 Register page: R0=8'h12, R1=8'h34, R2=8'h56, R3=8'h78, then release reset. Required response:
- frame_start pulses one cycle;
- AN=FF for 2 cycles, then FE for 6 cycles with nibble 1;
- continues through digit 7 = 7F with nibble 8;
- next frame_start arrives 65 cycles after the first.
REQ-032 Snapshot coherence: change R1 to 8'hAB in the middle of digit 2. Required response:
- the current frame still shows 3 and 4 on digits 2 and 3;
- the next frame shows A and B.
REQ-033 Hold: set hold=1 and change PC and R0..R3. Required response: display unchanged over 3 frames; new values appear the frame after hold drops.
REQ-034 Manual toggle: pulse page_req 3 times in one frame with PC=8'hC5. Required response:
- page goes to 1 at the next SNAP and stays there, i.e. exactly one toggle;
- digits show C and 5 with AN FE and FD;
- digits 2..7 keep AN=FF.
REQ-035 Auto-rotate: with auto_rotate=1, page toggles every 2 frames. When page_req coincides with the rotating SNAP, only one toggle occurs.
REQ-036 Reset mid-SHOW: assert rst between clock edges. Required response:
- AN=FF asynchronously;
- page=0;
- after release, a fresh SNAP and normal scan resume from digit 0.
